// File: rtl/decode_cycle_pkg.sv
// rtl/decode_cycle_pkg.sv - shared opcode, ALU, result-select and immediate-format codes
package decode_cycle_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [2:0] funct3;
    logic       zero_rd1;
    logic [2:0] imm_src;
  } ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } idex_t;

  // sub only exists for register-register ops, so callers pass sub_sel=0 for immediates
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] funct3, input logic sub_sel);
    logic [2:0] code;
    case (funct3)
      3'b000:  code = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// rtl/decode_cycle_reg_file.sv - 32x32 register file, x0 hardwired, write-through bypass
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // the writeback value is visible to a same-cycle read of the same register
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) rd1 = (wr_en && waddr == ra1) ? wdata : regs_q[ra1];
    if (ra2 != 5'd0) rd2 = (wr_en && waddr == ra2) ? wdata : regs_q[ra2];
  end

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - instruction decode, immediate generation and ID/EX pipeline register
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [2:0]  Funct3E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [31:0] imm_ext;
  ctrl_t       ctrl;
  idex_t       idex_d;
  idex_t       idex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd     = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  reg_file u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .we    (RegWriteW),
    .waddr (RdW),
    .wdata (ResultW),
    .ra1   (Rs1D),
    .ra2   (Rs2D),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // anything not listed, including the all-zero word, falls to the all-zero bubble
  always_comb begin
    ctrl         = '0;
    ctrl.imm_src = IMM_I;
    case (opcode)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_from_funct3(funct3, InstrD[30]);
        ctrl.funct3      = funct3;
      end
      OP_I_ALU: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_from_funct3(funct3, 1'b0);
        ctrl.funct3      = funct3;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.funct3     = funct3;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.funct3    = funct3;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.imm_src     = IMM_B;
        ctrl.funct3      = funct3;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_rd1  = 1'b1;
        ctrl.imm_src   = IMM_U;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ctrl.imm_src)
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      IMM_U:   imm_ext = {InstrD[31:12], 12'b0};
      default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write   = ctrl.reg_write;
      idex_d.mem_write   = ctrl.mem_write;
      idex_d.jump        = ctrl.jump;
      idex_d.branch      = ctrl.branch;
      idex_d.alu_src     = ctrl.alu_src;
      idex_d.result_src  = ctrl.result_src;
      idex_d.alu_control = ctrl.alu_control;
      idex_d.funct3      = ctrl.funct3;
      idex_d.rd1         = ctrl.zero_rd1 ? 32'd0 : rf_rd1;
      idex_d.rd2         = rf_rd2;
      idex_d.imm_ext     = imm_ext;
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.rd          = rd;
      idex_d.rs1         = Rs1D;
      idex_d.rs2         = Rs2D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_control;
  assign Funct3E     = idex_q.funct3;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - directed self-checking bench for decode_cycle
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E),
    .Rs2E(Rs2E)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; InstrD = 32'h00500093; PCD = 32'h40; PCPlus4D = 32'h44;
    FlushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    tick; tick;
    chk("rst_regwrite", RegWriteE, 0);
    chk("rst_immext", ImmExtE, 0);
    chk("rst_pc", PCE, 0);
    chk("rst_rd", RdE, 0);

    // addi x1,x0,5 captured on the first edge after release
    rst = 1'b1;
    tick;
    chk("addi_regwrite", RegWriteE, 1);
    chk("addi_alusrc", ALUSrcE, 1);
    chk("addi_imm", ImmExtE, 32'd5);
    chk("addi_rd", RdE, 1);
    chk("addi_aluctl", ALUControlE, 3'b000);
    chk("addi_pc", PCE, 32'h40);

    // write x5 while a bubble (InstrD=0) flows
    InstrD = 32'h0; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    tick;
    chk("zero_instr_regwrite", RegWriteE, 0);
    chk("zero_instr_alusrc", ALUSrcE, 0);
    RegWriteW = 1'b0; InstrD = 32'h00028133;
    #1;
    chk("rs1d_comb", Rs1D, 5);
    chk("rs2d_comb", Rs2D, 0);
    tick;
    chk("add_rd1", RD1E, 32'hDEADBEEF);
    chk("add_rd2", RD2E, 0);
    chk("add_rd", RdE, 2);
    chk("add_rs1e", Rs1E, 5);

    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h12345678;
    tick;
    chk("bypass_rd1", RD1E, 32'h12345678);

    InstrD = 32'h00000133; RdW = 5'd0; ResultW = 32'hFFFFFFFF;
    tick;
    chk("x0_bypass_rd1", RD1E, 0);
    chk("x0_bypass_rd2", RD2E, 0);
    RegWriteW = 1'b0;
    tick;
    chk("x0_stored_rd1", RD1E, 0);

    InstrD = 32'hFE000EE3;
    tick;
    chk("beq_branch", BranchE, 1);
    chk("beq_aluctl", ALUControlE, 3'b001);
    chk("beq_imm", ImmExtE, 32'hFFFFFFFC);
    chk("beq_regwrite", RegWriteE, 0);

    // flushed jal with a concurrent writeback of x7
    InstrD = 32'h008000EF; PCD = 32'h100; PCPlus4D = 32'h104; FlushE = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'hCAFEF00D;
    tick;
    chk("flush_jump", JumpE, 0);
    chk("flush_regwrite", RegWriteE, 0);
    chk("flush_resultsrc", ResultSrcE, 0);
    chk("flush_imm", ImmExtE, 0);
    chk("flush_pc", PCE, 0);
    chk("flush_pc4", PCPlus4E, 0);
    chk("flush_rd", RdE, 0);

    FlushE = 1'b0; RegWriteW = 1'b0;
    tick;
    chk("jal_jump", JumpE, 1);
    chk("jal_resultsrc", ResultSrcE, 2'b10);
    chk("jal_regwrite", RegWriteE, 1);
    chk("jal_imm", ImmExtE, 32'd8);
    chk("jal_alusrc", ALUSrcE, 0);
    chk("jal_pc4", PCPlus4E, 32'h104);

    InstrD = 32'h005381B3;
    tick;
    chk("flushwb_rd1", RD1E, 32'hCAFEF00D);
    chk("x5_rd2", RD2E, 32'h12345678);

    InstrD = 32'h40538233;
    tick;
    chk("sub_aluctl", ALUControlE, 3'b001);
    chk("sub_rd", RdE, 4);

    InstrD = 32'h0053A623;
    tick;
    chk("sw_memwrite", MemWriteE, 1);
    chk("sw_alusrc", ALUSrcE, 1);
    chk("sw_regwrite", RegWriteE, 0);
    chk("sw_imm", ImmExtE, 32'd12);
    chk("sw_funct3", Funct3E, 3'b010);

    InstrD = 32'hFF83A303;
    tick;
    chk("lw_resultsrc", ResultSrcE, 2'b01);
    chk("lw_imm", ImmExtE, 32'hFFFFFFF8);
    chk("lw_regwrite", RegWriteE, 1);

    // lui whose rs1 field (x27) is being bypassed must still see RD1=0
    InstrD = 32'hABCDE437; RegWriteW = 1'b1; RdW = 5'd27; ResultW = 32'h55;
    tick;
    chk("lui_imm", ImmExtE, 32'hABCDE000);
    chk("lui_rd1", RD1E, 0);
    chk("lui_alusrc", ALUSrcE, 1);
    chk("lui_regwrite", RegWriteE, 1);
    chk("lui_rd", RdE, 8);

    RegWriteW = 1'b0; InstrD = 32'h0000007F; PCD = 32'h200;
    tick;
    chk("ill_regwrite", RegWriteE, 0);
    chk("ill_alusrc", ALUSrcE, 0);
    chk("ill_jump", JumpE, 0);
    chk("ill_memwrite", MemWriteE, 0);
    chk("ill_pc", PCE, 32'h200);

    InstrD = 32'h0050D093;
    tick;
    chk("srli_aluctl", ALUControlE, 3'b111);
    chk("srli_imm", ImmExtE, 32'd5);

    // asynchronous reset mid-cycle, then writes blocked while held
    InstrD = 32'h005381B3;
    tick;
    chk("pre_rst_regwrite", RegWriteE, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_regwrite", RegWriteE, 0);
    chk("async_rst_rd1", RD1E, 0);
    chk("async_rst_pc", PCE, 0);
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h99;
    tick; tick;
    RegWriteW = 1'b0; rst = 1'b1; InstrD = 32'h005381B3;
    tick;
    chk("cleared_x7", RD1E, 0);
    chk("cleared_x5", RD2E, 0);
    InstrD = 32'h000481B3;
    tick;
    chk("blocked_x9", RD1E, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low; ports are clk and rst.
REQ-002 SHALL: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL: rst  input  1  async active-low reset.
REQ-004 SHALL: InstrD / PCD / PCPlus4D  input  32 each  instruction, PC and PC+4 from the IF/ID register.
REQ-005 SHALL: FlushE  input  1  load a bubble into ID/EX this edge.
REQ-006 SHALL: RegWriteW  input  1; RdW  input  5; ResultW  input  32  writeback port.
REQ-007 SHALL: Rs1D, Rs2D  output  5 each  combinational source indices, for the hazard unit.
REQ-008 SHALL: RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered control bits.
REQ-009 SHALL: ResultSrcE  output  2, ALUControlE  output  3, Funct3E  output  3  registered control fields.
REQ-010 SHALL: RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each; RdE, Rs1E, Rs2E  output  5 each  registered datapath.

Function
REQ-011 SHALL: ID/EX latency is exactly one clk; outputs change only on the rising edge or on reset.
REQ-012 SHALL: Rs1D = InstrD[19:15], Rs2D = InstrD[24:20], Rd = InstrD[11:7].
REQ-013 SHALL: register file is 32x32; x0 reads 0 always; writes to x0 are ignored.
REQ-014 SHALL: the write occurs on the rising edge when RegWriteW=1 and RdW!=0.
REQ-015 SHALL: write-through bypass applies in the same cycle: if RegWriteW=1, RdW!=0 and RdW==Rs1D (or Rs2D), the read returns ResultW.
REQ-016 SHALL: supported opcodes and decodes:
- R 0110011
- I-ALU 0010011
- load 0000011
- store 0100011
- branch 1100011
- jal 1101111
- lui 0110111
REQ-017 SHALL: immediates are sign-extended I/S/B/J formats; for U, ImmExt = {InstrD[31:12],12'b0}.
REQ-018 SHALL: ALUControl encodings:
- 000 add, 001 sub, 010 and, 011 or
- 100 xor, 101 slt, 110 sll, 111 srl
- R-type: funct7[5]=1 with funct3=000 gives sub.
- load, store and jal use add.
- branch uses sub.
- lui uses add with RD1 forced to 0.
REQ-019 SHALL: ResultSrc encodings: 00 = ALU, 01 = memory (load), 10 = PC+4 (jal).
REQ-020 SHALL: ALUSrc=1 for I-ALU, load, store and lui; RegWrite=1 for R, I-ALU, load, jal and lui.
REQ-021 SHALL: an unsupported opcode, or InstrD=0, decodes to all-zero control (bubble) while data fields are still registered.
REQ-022 SHALL: when FlushE=1 at an edge, every ID/EX output loads 0; this takes priority over the decoded values.
REQ-023 SHALL: if FlushE and a writeback are simultaneous, the register-file write still occurs.

Reset
REQ-024 SHALL: when rst=0, all ID/EX outputs become 0 immediately and asynchronously, regardless of clk.
REQ-025 SHALL: when rst=0, all 32 registers clear to 0, and writes are blocked while rst=0.
REQ-026 SHALL: on the first rising edge after rst rises, normal capture occurs.

Structure
REQ-027 SHALL: a shared package holds opcode constants, ALUControl codes, ResultSrc codes and ImmSrc codes.
REQ-028 SHALL: the register file is one sub-module named reg_file, which owns the bypass logic.
REQ-029 SHALL: control decode and immediate generation are combinational logic inside decode_cycle.

Verification
REQ-030 SHALL: rst=0 with InstrD=0x00500093 -> all outputs 0; after release, the edge gives RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
REQ-031 SHALL: write x5=0xDEADBEEF at RegWriteW=1, then InstrD=0x00028133 (add x2,x5,x0) -> RD1E=0xDEADBEEF, RD2E=0.
REQ-032 SHALL: same-cycle bypass (RdW=5, ResultW=0x12345678, Rs1D=5) -> RD1E=0x12345678; RdW=0 with ResultW=0xFFFFFFFF -> x0 still reads 0.
REQ-033 SHALL: InstrD=0xFE000EE3 (beq, offset -4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC, RegWriteE=0.
REQ-034 SHALL: FlushE=1 together with InstrD=jal -> all outputs 0 next cycle, and a concurrent writeback is still visible on a later read.
REQ-035 SHALL: InstrD=0x0000007F (illegal) -> all control 0; rst asserted mid-operation -> outputs 0 without a clock edge.
